rc_stage: RTL
=============

Name: rc_stage

Overview:
- Round-constant (RC) stage of the 24-round encoder permutation. Launched by the encoder controller through the RC_start/RC_finish handshake, with the current round index on iteration.
- Generates the 64-bit round constant for that round on the fly with the 8-bit LFSR (x^8+x^6+x^5+x^4+1); no constant table.
- XORs the constant into lane (0,0) of the shared lane memory by read-modify-write, then pulses finish so the controller can proceed to IT_CHECK.

Parameters:
LANE_W, 64, lane width in bits. Constant bit positions 0,1,3,7,15,31,63 require LANE_W=64.
ADDR_W, 5, lane memory address width (25 lanes).
LANE00_ADDR, 0, memory address of lane (0,0).

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  asynchronous, active-low reset (block is in reset while rst=0)
start  input  1  one-cycle launch pulse (driven by controller RC_start)
iteration  input  5  round index 0..23, sampled on the start cycle
finish  output  1  one-cycle completion pulse (drives controller RC_finish)
mem_addr  output  ADDR_W  lane memory address
mem_rd  output  1  read strobe; read data valid on mem_rdata in the following cycle
mem_rdata  input  LANE_W  lane memory read data
mem_wr  output  1  write strobe
mem_wdata  output  LANE_W  lane memory write data

Behaviour:
- Reset: rst=0 forces IDLE asynchronously. Reset values: finish=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, LFSR=8'h01, skip counter=0, rc bits=0.
- Reset mid-operation aborts the operation. No write is issued and memory is left untouched.
- LFSR step: r <= {r[6:0],1'b0} ^ (r[7] ? 8'h71 : 8'h00). rc(t) is r[0] after t steps from 8'h01.
- The constant for round i has bit (2^j - 1) = rc(7i+j) for j=0..6. All other bits are 0.
- FSM states and transitions (outputs are Moore decodes of state):
  - IDLE: on start=1, latch iteration, set LFSR=8'h01 and skip counter=7*iteration (8-bit). Go to SKIP if the count is nonzero, else GEN.
  - SKIP: step LFSR, decrement count. Go to GEN when count reaches 0. Occupies exactly 7*i cycles.
  - GEN: 7 cycles, j=0..6. Each cycle capture r[0] into rc bit j, then step LFSR. Then go to RD.
  - RD: mem_rd=1, mem_addr=LANE00_ADDR. Go to WAIT.
  - WAIT: register lane = mem_rdata XOR constant. Go to WR.
  - WR: mem_wr=1, mem_addr=LANE00_ADDR, mem_wdata=registered lane. Go to DONE.
  - DONE: finish=1 for one cycle. Go to IDLE.
- Latency: with the start edge as cycle 0, finish is high in cycle 7i+11 (i=0 gives 11, i=23 gives 172).
- Exactly one read and one write per operation, both at LANE00_ADDR. mem_addr is 0 in all other states.
- start while not IDLE is ignored. A change on iteration after the start cycle has no effect.
- start asserted in the DONE cycle is ignored. start in the first IDLE cycle after DONE is accepted.
- iteration > 23 is not flagged. The sequence is computed the same way, 7i wraps in 8 bits (max 217 for i=31).

Test Plan:
- i=0, lane00=64'h0 -> write 64'h0000000000000001, finish at cycle 11, one mem_rd, one mem_wr.
- i=1, lane00=64'hFFFFFFFFFFFFFFFF -> write 64'hFFFFFFFFFFFF7F7D (const 64'h8082), finish at cycle 18.
- i=2 and i=3, lane00=0 -> writes 64'h800000000000808A and 64'h8000000080008000.
- i=23, lane00=0 -> write 64'h8000000080008008, finish at cycle 172. Pulse start and change iteration during SKIP; both ignored.
- Full 24-round sweep i=0..23 on a lane starting at 0 -> final lane equals XOR of all 24 reference constants. Exactly 24 finish pulses.
- Drop rst low during SKIP for i=5 -> all outputs 0 immediately, no mem_wr. After release, start with i=5 -> correct constant 64'h0000000080000001 written.

Source files
------------

// File: rtl/rc_stage_if.sv
// rtl/rc_stage_if.sv - controller handshake and lane memory bus for the round-constant stage
interface rc_stage_if #(
    parameter int LANE_W = 64,
    parameter int ADDR_W = 5
);
    logic              start;
    logic [4:0]        iteration;
    logic              finish;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [LANE_W-1:0] mem_rdata;
    logic              mem_wr;
    logic [LANE_W-1:0] mem_wdata;

    modport master (
        output start, iteration, mem_rdata,
        input  finish, mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport slave (
        input  start, iteration, mem_rdata,
        output finish, mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/rc_stage.sv
// rtl/rc_stage.sv - round-constant stage: LFSR-generated constant XORed into lane (0,0)
module rc_stage #(
    parameter int LANE_W      = 64,
    parameter int ADDR_W      = 5,
    parameter int LANE00_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst,
    rc_stage_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, SKIP, GEN, RD, WAIT, WR, DONE} state_t;

    state_t      state;
    logic [7:0]  lfsr;
    logic [7:0]  skip_cnt;
    logic [2:0]  gen_idx;
    logic [6:0]  rc_bits;
    logic [7:0]  skip_init;
    logic [7:0]  lfsr_next;
    logic [LANE_W-1:0] rc_const;

    // 7*i wraps in 8 bits for out-of-range round indices
    assign skip_init = 8'({3'b000, bus.iteration} * 8'd7);
    assign lfsr_next = {lfsr[6:0], 1'b0} ^ (lfsr[7] ? 8'h71 : 8'h00);

    // Only bit positions 2^j-1 of the constant can be nonzero
    always_comb begin
        rc_const     = '0;
        rc_const[0]  = rc_bits[0];
        rc_const[1]  = rc_bits[1];
        rc_const[3]  = rc_bits[2];
        rc_const[7]  = rc_bits[3];
        rc_const[15] = rc_bits[4];
        rc_const[31] = rc_bits[5];
        rc_const[63] = rc_bits[6];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            lfsr          <= 8'h01;
            skip_cnt      <= 8'h00;
            gen_idx       <= 3'd0;
            rc_bits       <= 7'h00;
            bus.finish    <= 1'b0;
            bus.mem_rd    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.finish   <= 1'b0;
            bus.mem_rd   <= 1'b0;
            bus.mem_wr   <= 1'b0;
            bus.mem_addr <= '0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        lfsr     <= 8'h01;
                        skip_cnt <= skip_init;
                        gen_idx  <= 3'd0;
                        state    <= (skip_init != 8'h00) ? SKIP : GEN;
                    end
                end
                SKIP: begin
                    lfsr     <= lfsr_next;
                    skip_cnt <= skip_cnt - 8'd1;
                    if (skip_cnt == 8'd1) state <= GEN;
                end
                GEN: begin
                    rc_bits[gen_idx] <= lfsr[0];
                    lfsr             <= lfsr_next;
                    gen_idx          <= gen_idx + 3'd1;
                    if (gen_idx == 3'd6) begin
                        state        <= RD;
                        bus.mem_rd   <= 1'b1;
                        bus.mem_addr <= ADDR_W'(LANE00_ADDR);
                    end
                end
                RD: state <= WAIT;
                WAIT: begin
                    bus.mem_wdata <= bus.mem_rdata ^ rc_const;
                    bus.mem_wr    <= 1'b1;
                    bus.mem_addr  <= ADDR_W'(LANE00_ADDR);
                    state         <= WR;
                end
                WR: begin
                    bus.finish <= 1'b1;
                    state      <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
